unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one multi-cycle backing memory port between instruction fetch (IF) and the data-memory stage (DM) of the 5-stage pipelined CPU.
- Owns the grant FSM, the request/acknowledge handshakes, a starvation guard for IF and a response timeout.
- Drives a pipeline stall so the PC, IFID, IDEX, EXMEM and MEMWB registers hold while either stage waits on memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIM, 3, consecutive DM grants taken while IF is pending before IF is forced ahead.
- TIMEOUT, 64, GRANT-state cycles without mem_ack_i before the transaction is aborted.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request, level; held with if_addr_i stable until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o is high and held afterwards.
- dm_req_i  in  1  data request, level; held stable until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_ack_o  out  1  one-cycle data completion pulse.
- dm_rdata_o  out  DATA_W  read data, updated on reads only.
- mem_req_o  out  1  backend request, held until mem_ack_i or timeout.
- mem_we_o  out  1  backend write enable.
- mem_addr_o  out  ADDR_W  backend address.
- mem_wdata_o  out  DATA_W  backend write data.
- mem_ack_i  in  1  backend completion, one cycle.
- mem_rdata_i  in  DATA_W  backend read data, valid with mem_ack_i.
- stall_o  out  1  pipeline stall.
- err_o  out  1  timeout flag, pulses with the aborted transaction's ack.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM to IDLE; starve_cnt and wait_cnt to 0.
  - All registered outputs to 0: mem_*, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, err_o, busy_o.
  - Any in-flight transaction is dropped with no ack; a late mem_ack_i after reset release is ignored in IDLE.
- States: IDLE, GRANT_IF, GRANT_DM, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requesting: grant DM, unless starve_cnt==STARVE_LIM, then grant IF.
  - On grant, latch address/we/wdata into the mem_* registers. mem_req_o=1 from the next cycle (GRANT_x). IF grants drive mem_we_o=0.
- starve_cnt:
  - +1 (saturating at STARVE_LIM) on each DM grant made while if_req_i=1.
  - Cleared on every IF grant.
  - Unchanged otherwise.
- GRANT_x:
  - mem_req_o and the mem_* fields are held constant; wait_cnt increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the owner's rdata register (DM writes leave dm_rdata_o unchanged), clear mem_req_o, go to RESP.
  - If wait_cnt reaches TIMEOUT-1 without ack: clear mem_req_o, set the owner's rdata to 0 (DM writes unchanged), set the pending error flag, go to RESP.
- RESP:
  - For exactly one cycle: the owner's ack_o=1, err_o=1 only if timed out; wait_cnt cleared.
  - Then IDLE. Requests are re-sampled only in IDLE, so a held req is never issued twice.
- Latency: request visible in cycle 0 and mem_ack_i in cycle 1 gives ack_o in cycle 2 and IDLE in cycle 3. Back-to-back transaction throughput is 1 per 3 cycles minimum.
- mem_ack_i in IDLE or RESP is ignored.
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational; low during the ack cycle so the pipeline advances on that edge.
- busy_o = (state != IDLE), registered with the state.
- A requester dropping req mid-grant (flush) does not abort the backend transaction: it completes and its ack is still pulsed; the requester ignores it.

Test Plan:
- Reset, then single IF read of 0x10, backend acks 1 cycle after mem_req_o with 0x00A00093 -> mem_req_o high in cycle 1; if_ack_o pulse in cycle 3; if_rdata_o=0x00A00093; stall_o low in cycle 3.
- IF and DM request in the same cycle (DM read 0x20) -> DM granted first, dm_ack_o fires first; IF granted in the following IDLE; starve_cnt returns to 0 after the IF grant.
- IF held high while DM issues 4 back-to-back requests with STARVE_LIM=3 -> grant order DM, DM, DM, IF, DM.
- DM write 0x40 = 0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF held until ack; dm_rdata_o keeps its previous value.
- Backend never acks, TIMEOUT=64 -> mem_req_o drops after 64 GRANT cycles; owner ack and err_o pulse together; rdata=0; FSM in IDLE next cycle.
- rst_i asserted while in GRANT_DM, then mem_ack_i arrives after release -> all outputs 0 immediately; no dm_ack_o; the late mem_ack_i is ignored.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one multi-cycle backing memory port between the
//               instruction-fetch (IF) and data-memory (DM) pipeline stages.
//               Contains the grant FSM, request/ack handshakes, an IF
//               starvation guard, a backend response timeout and the
//               pipeline stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // data memory port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    // backing memory port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // status
    output logic              stall_o,
    output logic              err_o,
    output logic              busy_o
);

    // Counter widths; guarded so degenerate parameter values still give
    // at least a one-bit counter.
    localparam int SC_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_LIM);
    localparam logic [WC_W-1:0] C_WAIT_LAST  = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GRANT_IF = 2'd1,
        S_GRANT_DM = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [SC_W-1:0]   starve_q,    starve_d;
    logic [WC_W-1:0]   wait_q,      wait_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              dm_ack_q,    dm_ack_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              busy_q,      busy_d;

    logic              grant_if;
    logic              grant_dm;
    logic              owner_dm;
    logic              finish_txn;
    logic              timed_out;

    // Next-state, grant arbitration and datapath capture.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        owner_dm    = (state_q == S_GRANT_DM);
        finish_txn  = 1'b0;
        timed_out   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // DM normally wins a tie; IF is forced ahead once it has
                // been passed over STARVE_LIM times in a row.
                grant_if = if_req_i & (~dm_req_i | (starve_q == C_STARVE_MAX));
                grant_dm = dm_req_i & ~grant_if;
                wait_d   = '0;
                if (grant_if) begin
                    state_d     = S_GRANT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (grant_dm) begin
                    state_d     = S_GRANT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    if (if_req_i && (starve_q != C_STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            S_GRANT_IF, S_GRANT_DM: begin
                if (mem_ack_i) begin
                    finish_txn = 1'b1;
                end else if (wait_q == C_WAIT_LAST) begin
                    finish_txn = 1'b1;
                    timed_out  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end

                if (finish_txn) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    err_d     = timed_out;
                    if_ack_d  = ~owner_dm;
                    dm_ack_d  = owner_dm;
                    // An aborted read returns zero; writes never touch
                    // the DM read-data register.
                    if (!owner_dm) begin
                        if_rdata_d = timed_out ? '0 : mem_rdata_i;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = timed_out ? '0 : mem_rdata_i;
                    end
                end
            end

            S_RESP: begin
                // Ack/err pulse is visible this cycle; requests are only
                // re-sampled back in IDLE so a held req is not reissued.
                wait_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                wait_d    = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Stall drops in the ack cycle so the pipeline registers advance on
    // the edge that ends it.
    assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Scoreboard bench for unified_mem_arbiter. Stimulus pushes
//               expected grants and acks; independent monitors pop and
//               compare as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 3;
    localparam int TIMEOUT    = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;
    logic              err_o;
    logic              busy_o;

    unified_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_LIM(STARVE_LIM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_ack_o   (if_ack_o),
        .if_rdata_o (if_rdata_o),
        .dm_req_i   (dm_req_i),
        .dm_we_i    (dm_we_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_ack_o   (dm_ack_o),
        .dm_rdata_o (dm_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .stall_o    (stall_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        is_dm;
        logic [31:0] rdata;
        logic        err;
    } ack_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
    } gnt_exp_t;

    ack_exp_t    ack_q[$];
    gnt_exp_t    gnt_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_model [logic [31:0]];
    int          be_mode = 0;   // 0 = auto ack, 1 = never ack, 2 = manual
    int          be_dly  = 1;   // cycles after mem_req_o before auto ack

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        check32(name, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic push_ack(input logic is_dm, input logic [31:0] rdata, input logic err);
        ack_exp_t e;
        e.is_dm = is_dm; e.rdata = rdata; e.err = err;
        ack_q.push_back(e);
    endtask

    task automatic push_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        gnt_exp_t g;
        g.we = we; g.addr = addr; g.wdata = wdata; g.hold = hold;
        gnt_q.push_back(g);
    endtask

    task automatic if_txn(input logic [31:0] a);
        int n;
        n = 0;
        if_req_i  = 1'b1;
        if_addr_i = a;
        do begin
            @(negedge clk_i);
            n++;
        end while (!if_ack_o && n < 300);
        if (!if_ack_o) begin
            total++; bad++;
            $display("FAIL if_ack_wait: addr=%h got=no_ack exp=ack", a);
        end
        if_req_i = 1'b0;
    endtask

    task automatic dm_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        dm_req_i   = 1'b1;
        dm_we_i    = we;
        dm_addr_i  = a;
        dm_wdata_i = wd;
        do begin
            @(negedge clk_i);
            n++;
        end while (!dm_ack_o && n < 300);
        if (!dm_ack_o) begin
            total++; bad++;
            $display("FAIL dm_ack_wait: addr=%h got=no_ack exp=ack", a);
        end
        dm_req_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check1({tag, "_mem_req"}, mem_req_o, 1'b0);
        check1({tag, "_mem_we"}, mem_we_o, 1'b0);
        check32({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        check32({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        check1({tag, "_if_ack"}, if_ack_o, 1'b0);
        check1({tag, "_dm_ack"}, dm_ack_o, 1'b0);
        check32({tag, "_if_rdata"}, if_rdata_o, 32'h0);
        check32({tag, "_dm_rdata"}, dm_rdata_o, 32'h0);
        check1({tag, "_err"}, err_o, 1'b0);
        check1({tag, "_busy"}, busy_o, 1'b0);
    endtask

    // Backend memory model: acks be_dly cycles after seeing mem_req_o.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else if (be_mode == 0 && mem_req_o && rst_i) begin
                if (cnt == be_dly) begin
                    mem_ack_i = 1'b1;
                    cnt = 0;
                    if (mem_we_o) begin
                        mem_model[mem_addr_o] = mem_wdata_o;
                        mem_rdata_i = 32'hBAD0BAD0;
                    end else begin
                        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
                    end
                end else begin
                    cnt++;
                end
            end else if (!mem_req_o) begin
                cnt = 0;
            end
        end
    end

    // Grant monitor: checks every backend transaction against the expected
    // grant order, its fields while held, and how long mem_req_o stays up.
    initial begin
        gnt_exp_t g;
        int       hold;
        logic     active;
        hold   = 0;
        active = 1'b0;
        g.we = 1'b0; g.addr = '0; g.wdata = '0; g.hold = 0;
        forever begin
            @(negedge clk_i);
            if (mem_req_o) begin
                if (!active) begin
                    active = 1'b1;
                    hold   = 0;
                    if (gnt_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_grant: addr=%h exp=none", mem_addr_o);
                    end else begin
                        g = gnt_q.pop_front();
                    end
                end
                hold++;
                check32("grant_addr", mem_addr_o, g.addr);
                check1("grant_we", mem_we_o, g.we);
                if (g.we) check32("grant_wdata", mem_wdata_o, g.wdata);
            end else if (active) begin
                active = 1'b0;
                check32("grant_hold_cycles", 32'(hold), 32'(g.hold));
            end
        end
    end

    // Ack monitor: pops the expected completion whenever an ack pulses.
    initial begin
        ack_exp_t e;
        forever begin
            @(negedge clk_i);
            if (if_ack_o && dm_ack_o) begin
                total++; bad++;
                $display("FAIL dual_ack: if_ack=1 dm_ack=1 exp=one");
            end else if (if_ack_o || dm_ack_o) begin
                if (ack_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b exp=none", if_ack_o, dm_ack_o);
                end else begin
                    e = ack_q.pop_front();
                    check1("ack_owner_is_dm", dm_ack_o, e.is_dm);
                    check32("ack_rdata", e.is_dm ? dm_rdata_o : if_rdata_o, e.rdata);
                    check1("ack_err", err_o, e.err);
                end
            end else if (err_o) begin
                total++; bad++;
                $display("FAIL err_without_ack: err=1 exp=0");
            end
        end
    end

    // Watchdog against a hung handshake.
    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_model[32'h10]  = 32'h00A00093;
        mem_model[32'h14]  = 32'h00B00113;
        mem_model[32'h18]  = 32'h00C00193;
        mem_model[32'h20]  = 32'h11112222;
        mem_model[32'h100] = 32'hA1A1A1A1;
        mem_model[32'h104] = 32'hB2B2B2B2;
        mem_model[32'h108] = 32'hC3C3C3C3;
        mem_model[32'h10C] = 32'hD4D4D4D4;

        // Reset state
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        check1("reset_stall", stall_o, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Single IF read with cycle-exact latency checks
        push_gnt(1'b0, 32'h10, 32'h0, 2);
        push_ack(1'b0, 32'h00A00093, 1'b0);
        if_req_i = 1'b1; if_addr_i = 32'h10;          // cycle 0
        #1 check1("c0_stall", stall_o, 1'b1);
        check1("c0_mem_req", mem_req_o, 1'b0);
        @(negedge clk_i);                              // cycle 1
        check1("c1_mem_req", mem_req_o, 1'b1);
        check1("c1_busy", busy_o, 1'b1);
        @(negedge clk_i);                              // cycle 2
        check1("c2_stall", stall_o, 1'b1);
        check1("c2_if_ack", if_ack_o, 1'b0);
        @(negedge clk_i);                              // cycle 3
        check1("c3_if_ack", if_ack_o, 1'b1);
        check1("c3_stall", stall_o, 1'b0);
        check32("c3_if_rdata", if_rdata_o, 32'h00A00093);
        if_req_i = 1'b0;
        @(negedge clk_i);                              // cycle 4
        check1("c4_busy", busy_o, 1'b0);
        check1("c4_if_ack", if_ack_o, 1'b0);
        check32("c4_if_rdata_held", if_rdata_o, 32'h00A00093);

        // Simultaneous IF and DM: DM first, IF next
        push_gnt(1'b0, 32'h20, 32'h0, 2);
        push_gnt(1'b0, 32'h18, 32'h0, 2);
        push_ack(1'b1, 32'h11112222, 1'b0);
        push_ack(1'b0, 32'h00C00193, 1'b0);
        fork
            if_txn(32'h18);
            dm_txn(1'b0, 32'h20, 32'h0);
        join

        // IF held while DM streams four requests: DM, DM, DM, IF, DM
        push_gnt(1'b0, 32'h100, 32'h0, 2);
        push_gnt(1'b0, 32'h104, 32'h0, 2);
        push_gnt(1'b0, 32'h108, 32'h0, 2);
        push_gnt(1'b0, 32'h14,  32'h0, 2);
        push_gnt(1'b0, 32'h10C, 32'h0, 2);
        push_ack(1'b1, 32'hA1A1A1A1, 1'b0);
        push_ack(1'b1, 32'hB2B2B2B2, 1'b0);
        push_ack(1'b1, 32'hC3C3C3C3, 1'b0);
        push_ack(1'b0, 32'h00B00113, 1'b0);
        push_ack(1'b1, 32'hD4D4D4D4, 1'b0);
        fork
            if_txn(32'h14);
            begin
                dm_txn(1'b0, 32'h100, 32'h0);
                dm_txn(1'b0, 32'h104, 32'h0);
                dm_txn(1'b0, 32'h108, 32'h0);
                dm_txn(1'b0, 32'h10C, 32'h0);
            end
        join

        // DM write held for a slower backend, then read back
        be_dly = 3;
        push_gnt(1'b1, 32'h40, 32'hDEADBEEF, 4);
        push_ack(1'b1, 32'hD4D4D4D4, 1'b0);
        push_gnt(1'b0, 32'h40, 32'h0, 4);
        push_ack(1'b1, 32'hDEADBEEF, 1'b0);
        dm_txn(1'b1, 32'h40, 32'hDEADBEEF);
        dm_txn(1'b0, 32'h40, 32'h0);
        be_dly = 1;

        // Backend never answers: IF read then DM read both time out
        be_mode = 1;
        push_gnt(1'b0, 32'h80, 32'h0, TIMEOUT);
        push_ack(1'b0, 32'h0, 1'b1);
        if_txn(32'h80);
        @(negedge clk_i);
        check1("to_if_busy_after", busy_o, 1'b0);
        check1("to_if_err_after", err_o, 1'b0);
        push_gnt(1'b0, 32'h44, 32'h0, TIMEOUT);
        push_ack(1'b1, 32'h0, 1'b1);
        dm_txn(1'b0, 32'h44, 32'h0);
        @(negedge clk_i);
        check1("to_dm_busy_after", busy_o, 1'b0);
        be_mode = 0;

        // Give the read-data registers non-zero contents before reset
        push_gnt(1'b0, 32'h20, 32'h0, 2);
        push_ack(1'b1, 32'h11112222, 1'b0);
        dm_txn(1'b0, 32'h20, 32'h0);
        push_gnt(1'b0, 32'h10, 32'h0, 2);
        push_ack(1'b0, 32'h00A00093, 1'b0);
        if_txn(32'h10);

        // Reset during GRANT_DM, then a late backend ack in IDLE
        be_mode = 2;
        push_gnt(1'b0, 32'h20, 32'h0, 3);
        @(negedge clk_i);
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!mem_req_o && n < 20);
            if (!mem_req_o) begin
                total++; bad++;
                $display("FAIL rst_grant_wait: got=no_req exp=req");
            end
        end
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1 check_outputs_zero("midrst");
        dm_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1 mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check1("late_ack_dm_ack", dm_ack_o, 1'b0);
            check1("late_ack_busy", busy_o, 1'b0);
            check32("late_ack_dm_rdata", dm_rdata_o, 32'h0);
        end

        check32("ack_queue_empty", 32'(ack_q.size()), 32'h0);
        check32("grant_queue_empty", 32'(gnt_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
